// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: bundle of SPI pins and parallel word handshake for spi_slave_if.
//  SPI pins   : sclk, cs_n, mosi (master -> slave), miso, miso_oe (slave -> master)
//  TX side    : tx_data, tx_valid in; tx_ready, tx_underrun out
//  RX side    : rx_data, rx_valid out
//  Status     : busy, frame_err out
interface spi_slave_if_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             frame_err;
  logic             tx_underrun;

  // SPI target side
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );

  // SPI master / word-source side
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 target (CPOL=0, CPHA=0), MSB first.
//  SCLK/CS/MOSI are oversampled on clk_i through 2-flop synchronisers; edges are found by
//  comparing the 2nd sync stage against a 3rd delay flop. WIDTH-bit words are shifted in both
//  directions; multiple words per frame are supported while CS stays low.
// Ports:
//  clk_i   system clock (>= 12x SCLK)
//  rst_ni  asynchronous active-low reset
//  spi     spi_slave_if_if.slave: SPI pins, tx word handshake, rx word output, status pulses
module spi_slave_if #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] DUMMY = WIDTH'(8'hFF)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  spi_slave_if_if.slave  spi
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e           state_q;

  // Synchronisers: [0]=1st stage, [1]=2nd stage, [2]=edge-detect delay
  logic [2:0]       sclk_sync_q;
  logic [2:0]       cs_sync_q;
  logic [1:0]       mosi_sync_q;

  logic [CNT_W-1:0] bit_cnt_q;
  logic             wrap_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q;

  logic             miso_q;
  logic             miso_oe_q;
  logic             tx_ready_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             busy_q;
  logic             frame_err_q;
  logic             tx_underrun_q;

  logic             sclk_rise;
  logic             sclk_fall;
  logic             cs_fall;
  logic             cs_rise;
  logic             mosi_s;
  logic [WIDTH-1:0] rx_shift_d;
  logic [WIDTH-1:0] load_word_d;
  logic [WIDTH-1:0] tx_shift_d;

  // Edge detection on the synchronised pins
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  // Next values of the shifters
  assign rx_shift_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
  assign tx_shift_d  = {tx_shift_q[WIDTH-2:0], 1'b0};
  assign load_word_d = spi.tx_valid ? spi.tx_data : DUMMY;

  // Synchronisers, frame FSM, shifters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q   <= 3'b000;
      cs_sync_q     <= 3'b111;
      mosi_sync_q   <= 2'b00;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      wrap_q        <= 1'b0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_ready_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi.cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};

      // Single-cycle pulses default low
      tx_ready_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // SCLK activity while deselected is ignored
          if (cs_fall) begin
            state_q       <= ACTIVE;
            busy_q        <= 1'b1;
            miso_oe_q     <= 1'b1;
            bit_cnt_q     <= '0;
            wrap_q        <= 1'b0;
            tx_shift_q    <= load_word_d;
            miso_q        <= load_word_d[WIDTH-1];
            tx_ready_q    <= spi.tx_valid;
            tx_underrun_q <= ~spi.tx_valid;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // Deselect wins over a coincident SCLK edge; a partial word is dropped
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
            wrap_q      <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
              wrap_q     <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (wrap_q) begin
              // Word boundary inside a frame: fetch the next reply word
              wrap_q        <= 1'b0;
              tx_shift_q    <= load_word_d;
              miso_q        <= load_word_d[WIDTH-1];
              tx_ready_q    <= spi.tx_valid;
              tx_underrun_q <= ~spi.tx_valid;
            end else begin
              tx_shift_q <= tx_shift_d;
              miso_q     <= tx_shift_q[WIDTH-2];
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi.miso        = miso_q;
  assign spi.miso_oe     = miso_oe_q;
  assign spi.tx_ready    = tx_ready_q;
  assign spi.rx_data     = rx_data_q;
  assign spi.rx_valid    = rx_valid_q;
  assign spi.busy        = busy_q;
  assign spi.frame_err   = frame_err_q;
  assign spi.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: self-checking bench for spi_slave_if; a task-driven SPI mode-0 master plus a
// word-level reference (words sent must arrive; supplied words or DUMMY must be read back).
module tb_spi_slave_if;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;          // SCLK half-period in clk cycles
  localparam logic [W-1:0] DUMMY = 8'hFF;

  logic clk;
  logic rst_n;

  spi_slave_if_if #(.WIDTH(W)) bus ();

  spi_slave_if #(.WIDTH(W), .DUMMY(DUMMY)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .spi    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Tx word source: presents the head of txq, pops on tx_ready
  logic [W-1:0] txq[$];
  always @(negedge clk) begin
    if (bus.tx_ready === 1'b1 && txq.size() > 0) void'(txq.pop_front());
    bus.tx_valid = (txq.size() > 0);
    bus.tx_data  = (txq.size() > 0) ? txq[0] : '0;
  end

  // Output monitor
  logic [W-1:0] rxq[$];
  int n_txr, n_und, n_fe;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rxq.push_back(bus.rx_data);
    if (bus.tx_ready === 1'b1) n_txr++;
    if (bus.tx_underrun === 1'b1) n_und++;
    if (bus.frame_err === 1'b1) n_fe++;
  end

  logic [W-1:0] m_out[4];
  logic [W-1:0] m_in[4];
  logic         oe_seen, busy_seen;
  logic [W-1:0] last_rx;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    rxq.delete();
    n_txr = 0;
    n_und = 0;
    n_fe  = 0;
  endtask

  // Mode-0 master: n words from m_out, read into m_in. The final SCLK fall coincides with CS
  // rising. abort_rises>0 deselects after that many rising edges instead.
  task automatic master_frame(input int n, input int abort_rises);
    int rises;
    rises = 0;
    wait_clk(2);
    bus.cs_n = 1'b0;
    bus.mosi = m_out[0][W-1];
    wait_clk(H);
    oe_seen   = bus.miso_oe;
    busy_seen = bus.busy;
    for (int w = 0; w < n; w++) begin
      for (int b = W - 1; b >= 0; b--) begin
        m_in[w][b] = bus.miso;
        bus.sclk = 1'b1;
        rises++;
        wait_clk(H);
        if (abort_rises != 0 && rises == abort_rises) begin
          bus.sclk = 1'b0;
          wait_clk(H);
          bus.cs_n = 1'b1;
          bus.mosi = 1'b0;
          wait_clk(2 * H);
          return;
        end
        if (w == n - 1 && b == 0) begin
          bus.sclk = 1'b0;
          bus.cs_n = 1'b1;
        end else begin
          bus.sclk = 1'b0;
          bus.mosi = (b > 0) ? m_out[w][b-1] : m_out[w+1][W-1];
        end
        wait_clk(H);
      end
    end
    bus.mosi = 1'b0;
    wait_clk(2 * H);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clk(3);
    tests_run++;
    if ({bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_valid, bus.busy, bus.frame_err,
         bus.tx_underrun} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b required 0000000", {bus.miso, bus.miso_oe, bus.tx_ready,
               bus.rx_valid, bus.busy, bus.frame_err, bus.tx_underrun});
    end
    tests_run++;
    if (bus.rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_rx_data got %h required 00", bus.rx_data);
    end
    rst_n = 1'b1;
    wait_clk(4);
    last_rx = 8'h00;
  endtask

  task automatic test_single_word();
    clear_mon();
    txq.push_back(8'h3C);
    m_out[0] = 8'hA5;
    master_frame(1, 0);
    tests_run++;
    if (rxq.size() != 1 || bus.rx_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL t1_rx got %0d words rx_data=%h required 1 word A5", rxq.size(), bus.rx_data);
    end
    tests_run++;
    if (m_in[0] !== 8'h3C) begin
      tests_failed++;
      $display("FAIL t1_miso got %h required 3C", m_in[0]);
    end
    tests_run++;
    if (n_txr != 1 || n_fe != 0 || n_und != 0) begin
      tests_failed++;
      $display("FAIL t1_pulses got txr=%0d fe=%0d und=%0d required 1 0 0", n_txr, n_fe, n_und);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || busy_seen !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_busy got during=%b after=%b required 1 0", busy_seen, bus.busy);
    end
    last_rx = 8'hA5;
  endtask

  task automatic test_multi_word();
    logic [W-1:0] exp_tx[3];
    clear_mon();
    exp_tx = '{8'h10, 8'h20, 8'h30};
    for (int k = 0; k < 3; k++) begin
      txq.push_back(exp_tx[k]);
      m_out[k] = W'(k + 1);
    end
    master_frame(3, 0);
    tests_run++;
    if (rxq.size() != 3) begin
      tests_failed++;
      $display("FAIL t2_rx_count got %0d required 3", rxq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rxq[k] !== W'(k + 1)) begin
          tests_failed++;
          $display("FAIL t2_rx_word%0d got %h required %h", k, rxq[k], W'(k + 1));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (m_in[k] !== exp_tx[k]) begin
        tests_failed++;
        $display("FAIL t2_miso_word%0d got %h required %h", k, m_in[k], exp_tx[k]);
      end
    end
    tests_run++;
    if (n_txr != 3 || n_und != 0) begin
      tests_failed++;
      $display("FAIL t2_tx_ready got txr=%0d und=%0d required 3 0", n_txr, n_und);
    end
    last_rx = 8'h03;
  endtask

  task automatic test_underrun();
    clear_mon();
    m_out[0] = 8'h5E;
    master_frame(1, 0);
    tests_run++;
    if (m_in[0] !== DUMMY) begin
      tests_failed++;
      $display("FAIL t3_dummy got %h required %h", m_in[0], DUMMY);
    end
    tests_run++;
    if (n_und != 1 || n_txr != 0) begin
      tests_failed++;
      $display("FAIL t3_underrun got und=%0d txr=%0d required 1 0", n_und, n_txr);
    end
    tests_run++;
    if (oe_seen !== 1'b1) begin
      tests_failed++;
      $display("FAIL t3_miso_oe got %b required 1", oe_seen);
    end
    last_rx = 8'h5E;
  endtask

  task automatic test_frame_abort();
    clear_mon();
    txq.push_back(8'h77);
    m_out[0] = 8'hE1;
    master_frame(1, 5);
    tests_run++;
    if (n_fe != 1) begin
      tests_failed++;
      $display("FAIL t4_frame_err got %0d pulses required 1", n_fe);
    end
    tests_run++;
    if (rxq.size() != 0 || bus.rx_data !== last_rx) begin
      tests_failed++;
      $display("FAIL t4_rx_hold got %0d words rx_data=%h required 0 words %h", rxq.size(),
               bus.rx_data, last_rx);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.miso_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_idle got busy=%b oe=%b required 0 0", bus.busy, bus.miso_oe);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] pat;
    clear_mon();
    txq.push_back(8'h99);
    pat = 8'hB6;
    wait_clk(2);
    bus.cs_n = 1'b0;
    bus.mosi = pat[7];
    wait_clk(H);
    for (int b = 7; b >= 4; b--) begin
      bus.sclk = 1'b1;
      wait_clk(H);
      bus.sclk = 1'b0;
      bus.mosi = pat[b-1];
      wait_clk(H);
    end
    bus.sclk = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_valid, bus.busy, bus.frame_err,
         bus.tx_underrun} !== 7'b0 || bus.rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL t5_async_reset got flags=%b rx_data=%h required 0000000 00", {bus.miso,
               bus.miso_oe, bus.tx_ready, bus.rx_valid, bus.busy, bus.frame_err, bus.tx_underrun},
               bus.rx_data);
    end
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(6);
    txq.delete();
    tests_run++;
    if (n_fe != 0 || rxq.size() != 0) begin
      tests_failed++;
      $display("FAIL t5_silent_abort got fe=%0d rx=%0d required 0 0", n_fe, rxq.size());
    end
    clear_mon();
    txq.push_back(8'h5A);
    m_out[0] = 8'hC3;
    master_frame(1, 0);
    tests_run++;
    if (rxq.size() != 1 || bus.rx_data !== 8'hC3 || m_in[0] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL t5_after_reset got rx=%0d words rx_data=%h miso=%h required 1 C3 5A",
               rxq.size(), bus.rx_data, m_in[0]);
    end
    last_rx = 8'hC3;
  endtask

  // Random frames of 1..4 words; supply either all reply words or none (expect DUMMY)
  task automatic test_random_loopback();
    logic [W-1:0] exp_tx[4];
    int words, n, supply, rx_bad, tx_bad;
    words  = 0;
    rx_bad = 0;
    tx_bad = 0;
    while (words < 256) begin
      n = int'($urandom_range(1, 4));
      if (words + n > 256) n = 256 - words;
      supply = ($urandom_range(0, 3) != 0) ? 1 : 0;
      clear_mon();
      for (int k = 0; k < n; k++) begin
        m_out[k]  = W'($urandom);
        exp_tx[k] = supply != 0 ? W'($urandom) : DUMMY;
        if (supply != 0) txq.push_back(exp_tx[k]);
      end
      master_frame(n, 0);
      tests_run++;
      if (rxq.size() != n || n_und != (supply != 0 ? 0 : n) || n_txr != (supply != 0 ? n : 0)) begin
        tests_failed++;
        $display("FAIL t6_frame_counts got rx=%0d und=%0d txr=%0d required %0d %0d %0d",
                 rxq.size(), n_und, n_txr, n, supply != 0 ? 0 : n, supply != 0 ? n : 0);
      end else begin
        for (int k = 0; k < n; k++) begin
          tests_run++;
          if (rxq[k] !== m_out[k]) begin
            tests_failed++;
            rx_bad++;
            $display("FAIL t6_rx word%0d got %h required %h", words + k, rxq[k], m_out[k]);
          end
          tests_run++;
          if (m_in[k] !== exp_tx[k]) begin
            tests_failed++;
            tx_bad++;
            $display("FAIL t6_miso word%0d got %h required %h", words + k, m_in[k], exp_tx[k]);
          end
        end
      end
      words += n;
    end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    test_reset();
    test_single_word();
    test_multi_word();
    test_underrun();
    test_frame_abort();
    test_reset_mid_word();
    test_random_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout simulation did not complete within bound");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
